actuator_scheduler: RTL and testbench

- Sequential replacement for the scan-counter/priority-latch path of the home automation controller. It arbitrates sensor-derived requests for the six actuators and grants exactly one actuator at a time.
- Each grant holds for a programmable minimum dwell time, followed by a mandatory all-off gap cycle. An alarm request preempts any other grant.
- Drives the existing one-hot actuator outputs and the 3-bit display code. Code map: 000 idle, 001 front_door, 010 rear_door, 011 alarm_buzzer, 100 window_buzzer, 101 heater, 110 cooler.

---
 rtl/home_auto_pkg.sv | 79 +++++++
 rtl/request_arbiter.sv | 70 +++++++
 rtl/actuator_scheduler.sv | 166 ++++++++++++++++
 tb/tb_actuator_scheduler.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/home_auto_pkg.sv
// home_auto_pkg: shared types and constants for the actuator scheduler.
// Action codes double as the display encoding; request indices fix the
// bit order of both the request vector and the one-hot actuator vector.
// The rotation helpers are only referenced when ROUND_ROBIN_EN is defined.
package home_auto_pkg;

    typedef logic [2:0] action_t;

    localparam action_t ACT_IDLE          = 3'b000;
    localparam action_t ACT_FRONT_DOOR    = 3'b001;
    localparam action_t ACT_REAR_DOOR     = 3'b010;
    localparam action_t ACT_ALARM_BUZZER  = 3'b011;
    localparam action_t ACT_WINDOW_BUZZER = 3'b100;
    localparam action_t ACT_HEATER        = 3'b101;
    localparam action_t ACT_COOLER        = 3'b110;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        GAP   = 2'b10
    } state_t;

    // Request vector / one-hot actuator vector bit positions
    localparam int REQ_ALARM = 0;
    localparam int REQ_FD    = 1;
    localparam int REQ_RD    = 2;
    localparam int REQ_WIN   = 3;
    localparam int REQ_HEAT  = 4;
    localparam int REQ_COOL  = 5;
    localparam int REQ_W     = 6;

    // Number of rotating (non-alarm) entries: fd, rd, win, heat, cool
    localparam int RR_N = 5;

    // Action code to one-hot actuator vector in request-index order
    function automatic logic [REQ_W-1:0] action_to_onehot(input action_t code);
        logic [REQ_W-1:0] oh;
        oh = 6'b000000;
        case (code)
            ACT_FRONT_DOOR:    oh[REQ_FD]    = 1'b1;
            ACT_REAR_DOOR:     oh[REQ_RD]    = 1'b1;
            ACT_ALARM_BUZZER:  oh[REQ_ALARM] = 1'b1;
            ACT_WINDOW_BUZZER: oh[REQ_WIN]   = 1'b1;
            ACT_HEATER:        oh[REQ_HEAT]  = 1'b1;
            ACT_COOLER:        oh[REQ_COOL]  = 1'b1;
            default:           oh            = 6'b000000;
        endcase
        return oh;
    endfunction

    // Rotation slot (0 = fd .. 4 = cool) to action code
    function automatic action_t rr_entry_code(input logic [2:0] slot);
        action_t code;
        case (slot)
            3'd0:    code = ACT_FRONT_DOOR;
            3'd1:    code = ACT_REAR_DOOR;
            3'd2:    code = ACT_WINDOW_BUZZER;
            3'd3:    code = ACT_HEATER;
            3'd4:    code = ACT_COOLER;
            default: code = ACT_IDLE;
        endcase
        return code;
    endfunction

    // Slot following a completed grant; this becomes the new rotation start
    function automatic logic [2:0] rr_next_ptr(input action_t code);
        logic [2:0] ptr;
        case (code)
            ACT_FRONT_DOOR:    ptr = 3'd1;
            ACT_REAR_DOOR:     ptr = 3'd2;
            ACT_WINDOW_BUZZER: ptr = 3'd3;
            ACT_HEATER:        ptr = 3'd4;
            ACT_COOLER:        ptr = 3'd0;
            default:           ptr = 3'd0;
        endcase
        return ptr;
    endfunction

endpackage

// File: rtl/request_arbiter.sv
// request_arbiter: combinational winner selection over the 6-bit request
// vector. Alarm always wins. The remaining five requests use fixed priority
// fd > rd > win > heat > cool, or rotating priority starting at ptr_i when
// ROUND_ROBIN_EN is defined.
module request_arbiter
    import home_auto_pkg::*;
(
    input  logic [5:0] req_i,
`ifdef ROUND_ROBIN_EN
    input  logic [2:0] ptr_i,
`endif
    output logic [2:0] win_code_o
);

    action_t win_code_s;

`ifdef ROUND_ROBIN_EN
    logic [4:0] rr_req_s;
    logic [3:0] slot_s;
    logic [3:0] sum_s;
    logic       found_s;

    assign rr_req_s = req_i[REQ_COOL:REQ_FD];

    // Alarm first, then scan the five rotating slots starting at the pointer
    always_comb begin
        win_code_s = ACT_IDLE;
        found_s    = 1'b0;
        slot_s     = 4'd0;
        sum_s      = 4'd0;
        if (req_i[REQ_ALARM]) begin
            win_code_s = ACT_ALARM_BUZZER;
        end else begin
            for (int k = 0; k < RR_N; k++) begin
                sum_s  = {1'b0, ptr_i} + 4'(k);
                slot_s = (sum_s >= 4'd5) ? (sum_s - 4'd5) : sum_s;
                if (!found_s && rr_req_s[slot_s[2:0]]) begin
                    found_s    = 1'b1;
                    win_code_s = rr_entry_code(slot_s[2:0]);
                end else begin
                    found_s    = found_s;
                end
            end
        end
    end
`else
    // Strict fixed priority: alarm > fd > rd > win > heat > cool
    always_comb begin
        win_code_s = ACT_IDLE;
        if (req_i[REQ_ALARM]) begin
            win_code_s = ACT_ALARM_BUZZER;
        end else if (req_i[REQ_FD]) begin
            win_code_s = ACT_FRONT_DOOR;
        end else if (req_i[REQ_RD]) begin
            win_code_s = ACT_REAR_DOOR;
        end else if (req_i[REQ_WIN]) begin
            win_code_s = ACT_WINDOW_BUZZER;
        end else if (req_i[REQ_HEAT]) begin
            win_code_s = ACT_HEATER;
        end else if (req_i[REQ_COOL]) begin
            win_code_s = ACT_COOLER;
        end else begin
            win_code_s = ACT_IDLE;
        end
    end
`endif

    assign win_code_o = win_code_s;

endmodule

// File: rtl/actuator_scheduler.sv
// actuator_scheduler: grants one of six actuators at a time for DWELL
// cycles, followed by exactly one all-off gap cycle. A non-alarm grant is
// cut short by the fire alarm; an alarm grant always runs its full dwell.
// All actuator, display and busy outputs are registered.
// Optional macro: ROUND_ROBIN_EN (rotating priority for non-alarm requests).
module actuator_scheduler
    import home_auto_pkg::*;
#(
    parameter int DWELL       = 8,
    parameter int HEAT_THRESH = 9,
    parameter int COOL_THRESH = 30,
    parameter int CNT_W       = $clog2(DWELL + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SFD,
    input  logic       SRD,
    input  logic       SFA,
    input  logic       SW,
    input  logic       ST,
    input  logic [5:0] temperature,
    output logic       front_door,
    output logic       rear_door,
    output logic       alarm_buzzer,
    output logic       window_buzzer,
    output logic       heater,
    output logic       cooler,
    output logic [2:0] display,
    output logic       busy
);

    localparam logic [5:0]       HEAT_T     = 6'(HEAT_THRESH);
    localparam logic [5:0]       COOL_T     = 6'(COOL_THRESH);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [REQ_W-1:0] req_s;
    logic             heat_s;
    logic             cool_raw_s;
    logic             any_req_s;
    logic             preempt_s;
    action_t          win_code_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    action_t          code_q, code_d;
    logic [REQ_W-1:0] act_q;
    logic             busy_q;

`ifdef ROUND_ROBIN_EN
    logic [2:0]       ptr_q, ptr_d;
`endif

    assign heat_s     = ST & (temperature < HEAT_T);
    assign cool_raw_s = ST & (temperature >= COOL_T);

    // Build the request vector; heat masks cool when both thresholds hit
    always_comb begin
        req_s            = 6'b000000;
        req_s[REQ_ALARM] = SFA;
        req_s[REQ_FD]    = SFD;
        req_s[REQ_RD]    = SRD;
        req_s[REQ_WIN]   = SW;
        req_s[REQ_HEAT]  = heat_s;
        req_s[REQ_COOL]  = cool_raw_s & ~heat_s;
    end

    assign any_req_s = |req_s;
    assign preempt_s = req_s[REQ_ALARM] & (code_q != ACT_ALARM_BUZZER);

    request_arbiter u_arbiter (
        .req_i      (req_s),
`ifdef ROUND_ROBIN_EN
        .ptr_i      (ptr_q),
`endif
        .win_code_o (win_code_s)
    );

    // Next-state logic: arbitration in IDLE/GAP, dwell countdown in SERVE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
`ifdef ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE, GAP: begin
                if (any_req_s) begin
                    state_d = SERVE;
                    code_d  = win_code_s;
                    cnt_d   = DWELL_LOAD;
                end else begin
                    state_d = IDLE;
                    code_d  = ACT_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            end
            SERVE: begin
                if (cnt_q == CNT_ZERO) begin
                    // Full dwell served; only completed grants move the pointer
                    state_d = GAP;
                    code_d  = ACT_IDLE;
                    cnt_d   = CNT_ZERO;
`ifdef ROUND_ROBIN_EN
                    if (code_q != ACT_ALARM_BUZZER) begin
                        ptr_d = rr_next_ptr(code_q);
                    end else begin
                        ptr_d = ptr_q;
                    end
`endif
                end else if (preempt_s) begin
                    state_d = GAP;
                    code_d  = ACT_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = ACT_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and registered outputs; async active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            code_q  <= ACT_IDLE;
            act_q   <= 6'b000000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            act_q   <= action_to_onehot(code_d);
            busy_q  <= (state_d != IDLE);
        end
    end

`ifdef ROUND_ROBIN_EN
    // Rotation pointer, starting at the front-door slot after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign front_door    = act_q[REQ_FD];
    assign rear_door     = act_q[REQ_RD];
    assign alarm_buzzer  = act_q[REQ_ALARM];
    assign window_buzzer = act_q[REQ_WIN];
    assign heater        = act_q[REQ_HEAT];
    assign cooler        = act_q[REQ_COOL];
    assign display       = code_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_actuator_scheduler.sv
// tb_actuator_scheduler: directed scenario tasks plus a random invariant
// sweep. Inputs change on the falling edge; outputs are sampled on the
// falling edge before inputs move.
module tb_actuator_scheduler;

    logic       clk;
    logic       reset;
    logic       SFD, SRD, SFA, SW, ST;
    logic [5:0] temperature;
    logic       front_door, rear_door, alarm_buzzer, window_buzzer, heater, cooler;
    logic [2:0] display;
    logic       busy;
    logic [5:0] act;

    int n_cmp = 0;
    int n_err = 0;

    actuator_scheduler #(
        .DWELL       (8),
        .HEAT_THRESH (9),
        .COOL_THRESH (30)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .SFD           (SFD),
        .SRD           (SRD),
        .SFA           (SFA),
        .SW            (SW),
        .ST            (ST),
        .temperature   (temperature),
        .front_door    (front_door),
        .rear_door     (rear_door),
        .alarm_buzzer  (alarm_buzzer),
        .window_buzzer (window_buzzer),
        .heater        (heater),
        .cooler        (cooler),
        .display       (display),
        .busy          (busy)
    );

    assign act = {cooler, heater, window_buzzer, alarm_buzzer, rear_door, front_door};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected actuator vector {cooler,heater,window,alarm,rear,front} per code
    function automatic logic [5:0] exp_onehot(input logic [2:0] code);
        case (code)
            3'b001:  return 6'b000001;
            3'b010:  return 6'b000010;
            3'b011:  return 6'b000100;
            3'b100:  return 6'b001000;
            3'b101:  return 6'b010000;
            3'b110:  return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic clear_inputs();
        SFD = 1'b0; SRD = 1'b0; SFA = 1'b0; SW = 1'b0; ST = 1'b0;
        temperature = 6'd0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy !== 1'b0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (act !== 6'b0) begin n_err++; $display("FAIL reset_act: got %b expected %b", act, 6'b0); end
        n_cmp++; if (display !== 3'b000) begin n_err++; $display("FAIL reset_disp: got %b expected %b", display, 3'b000); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        @(negedge clk); SFD = 1'b1;
        @(negedge clk);
        n_cmp++; if (act !== 6'b000001 || display !== 3'b001) begin n_err++; $display("FAIL rmg_grant: got act=%b disp=%b expected act=000001 disp=001", act, display); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (act !== 6'b0 || display !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL rmg_async: got act=%b disp=%b busy=%b expected all zero", act, display, busy); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (act !== 6'b000001 || display !== 3'b001 || busy !== 1'b1) begin n_err++; $display("FAIL rmg_regrant: got act=%b disp=%b busy=%b expected 000001/001/1", act, display, busy); end
        SFD = 1'b0;
        wait_idle(cyc);
        n_cmp++; if (cyc >= 40) begin n_err++; $display("FAIL rmg_idle_timeout: got %0d cycles expected < 40", cyc); end
    endtask

    task automatic test_dwell_gap();
        @(negedge clk); SRD = 1'b1;
        @(negedge clk); SRD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (act !== 6'b000010 || display !== 3'b010 || busy !== 1'b1) begin n_err++; $display("FAIL dwell[%0d]: got act=%b disp=%b busy=%b expected 000010/010/1", i, act, display, busy); end
            @(negedge clk);
        end
        n_cmp++; if (act !== 6'b0 || display !== 3'b000 || busy !== 1'b1) begin n_err++; $display("FAIL dwell_gap: got act=%b disp=%b busy=%b expected 000000/000/1", act, display, busy); end
        @(negedge clk);
        n_cmp++; if (display !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL dwell_idle: got disp=%b busy=%b expected 000/0", display, busy); end
    endtask

    task automatic test_preempt();
        int cyc;
        @(negedge clk); SW = 1'b1;
        @(negedge clk); SW = 1'b0;
        n_cmp++; if (act !== 6'b001000 || display !== 3'b100) begin n_err++; $display("FAIL pre_win: got act=%b disp=%b expected 001000/100", act, display); end
        @(negedge clk);
        @(negedge clk); SFA = 1'b1;
        n_cmp++; if (window_buzzer !== 1'b1) begin n_err++; $display("FAIL pre_win_c3: got %b expected %b", window_buzzer, 1'b1); end
        @(negedge clk);
        n_cmp++; if (act !== 6'b0 || display !== 3'b000 || busy !== 1'b1) begin n_err++; $display("FAIL pre_gap: got act=%b disp=%b busy=%b expected 000000/000/1", act, display, busy); end
        @(negedge clk); SFA = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (act !== 6'b000100 || display !== 3'b011) begin n_err++; $display("FAIL pre_alarm[%0d]: got act=%b disp=%b expected 000100/011", i, act, display); end
            @(negedge clk);
        end
        n_cmp++; if (act !== 6'b0 || busy !== 1'b1) begin n_err++; $display("FAIL pre_alarm_gap: got act=%b busy=%b expected 000000/1", act, busy); end
        wait_idle(cyc);
        n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL pre_idle: got %0d cycles expected 1", cyc); end
    endtask

    task automatic test_thermal();
        int cyc;
        @(negedge clk); ST = 1'b1; temperature = 6'd5;
        @(negedge clk);
        n_cmp++; if (act !== 6'b010000 || display !== 3'b101) begin n_err++; $display("FAIL th_heat[0]: got act=%b disp=%b expected 010000/101", act, display); end
        temperature = 6'd45;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            n_cmp++; if (act !== 6'b010000 || display !== 3'b101) begin n_err++; $display("FAIL th_heat[%0d]: got act=%b disp=%b expected 010000/101", i, act, display); end
        end
        @(negedge clk);
        n_cmp++; if (act !== 6'b0 || display !== 3'b000) begin n_err++; $display("FAIL th_gap: got act=%b disp=%b expected 000000/000", act, display); end
        @(negedge clk);
        n_cmp++; if (act !== 6'b100000 || display !== 3'b110) begin n_err++; $display("FAIL th_cool: got act=%b disp=%b expected 100000/110", act, display); end
        temperature = 6'd20;
        wait_idle(cyc);
        n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL th_cool_len: got %0d cycles expected 9", cyc); end
        repeat (3) @(negedge clk);
        n_cmp++; if (display !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL th_none: got disp=%b busy=%b expected 000/0", display, busy); end
        clear_inputs();
    endtask

    task automatic test_thresholds();
        logic [5:0] temps [7];
        logic [2:0] codes [7];
        logic       valid [7];
        int cyc;
        temps = '{6'd8, 6'd9, 6'd29, 6'd30, 6'd63, 6'd0, 6'd5};
        codes = '{3'b101, 3'b000, 3'b000, 3'b110, 3'b110, 3'b101, 3'b000};
        valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk); ST = valid[i]; temperature = temps[i];
            @(negedge clk);
            n_cmp++; if (display !== codes[i] || act !== exp_onehot(codes[i])) begin n_err++; $display("FAIL thr[temp=%0d st=%b]: got disp=%b act=%b expected disp=%b", temps[i], valid[i], display, act, codes[i]); end
            clear_inputs();
            wait_idle(cyc);
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp_seq [4];
        int t;
        int cyc;
`ifdef ROUND_ROBIN_EN
        exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        SFD = 1'b1; SRD = 1'b1; SW = 1'b1;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (display === 3'b000 && t < 20) begin @(negedge clk); t++; end
            n_cmp++; if (display !== exp_seq[k]) begin n_err++; $display("FAIL prio_seq[%0d]: got %b expected %b", k, display, exp_seq[k]); end
            if (k > 0) begin
                n_cmp++; if (t !== 1) begin n_err++; $display("FAIL prio_gap[%0d]: got %0d expected 1", k, t); end
            end
            t = 0;
            while (display !== 3'b000 && t < 20) begin @(negedge clk); t++; end
            n_cmp++; if (t !== 8) begin n_err++; $display("FAIL prio_dwell[%0d]: got %0d expected 8", k, t); end
        end
        clear_inputs();
        wait_idle(cyc);
    endtask

    task automatic test_alarm_hold();
        int t;
        int cyc;
        @(negedge clk); SFA = 1'b1; SFD = 1'b1;
        for (int k = 0; k < 2; k++) begin
            t = 0;
            while (display === 3'b000 && t < 20) begin @(negedge clk); t++; end
            n_cmp++; if (display !== 3'b011 || act !== 6'b000100) begin n_err++; $display("FAIL alarm_hold[%0d]: got disp=%b act=%b expected 011/000100", k, display, act); end
            t = 0;
            while (display !== 3'b000 && t < 20) begin @(negedge clk); t++; end
            n_cmp++; if (t !== 8) begin n_err++; $display("FAIL alarm_dwell[%0d]: got %0d expected 8", k, t); end
        end
        clear_inputs();
        wait_idle(cyc);
        n_cmp++; if (cyc !== 1) begin n_err++; $display("FAIL alarm_idle: got %0d cycles expected 1", cyc); end
    endtask

    task automatic test_random();
        logic [2:0] prev_disp;
        int cyc;
        prev_disp = display;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            n_cmp++; if ($countones(act) > 1) begin n_err++; $display("FAIL rnd_onehot[%0d]: got %b expected at most one bit", c, act); end
            n_cmp++; if (act !== exp_onehot(display)) begin n_err++; $display("FAIL rnd_decode[%0d]: got act=%b expected %b for disp=%b", c, act, exp_onehot(display), display); end
            n_cmp++; if (prev_disp !== 3'b000 && display !== 3'b000 && display !== prev_disp) begin n_err++; $display("FAIL rnd_nogap[%0d]: got %b after %b expected a gap between", c, display, prev_disp); end
            n_cmp++; if (display !== 3'b000 && busy !== 1'b1) begin n_err++; $display("FAIL rnd_busy[%0d]: got busy=%b expected 1 for disp=%b", c, busy, display); end
            prev_disp   = display;
            SFA         = ($urandom_range(15) == 0);
            SFD         = 1'($urandom_range(1));
            SRD         = 1'($urandom_range(1));
            SW          = 1'($urandom_range(1));
            ST          = 1'($urandom_range(1));
            temperature = 6'($urandom_range(63));
        end
        clear_inputs();
        wait_idle(cyc);
        n_cmp++; if (cyc >= 40) begin n_err++; $display("FAIL rnd_idle_timeout: got %0d cycles expected < 40", cyc); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_grant();
        test_dwell_gap();
        test_preempt();
        test_thermal();
        test_thresholds();
        test_priority();
        test_alarm_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
